// File: rtl/l1_pkg.sv
// l1_pkg: shared definitions for the L1-I bus refill controller.
// Holds the sequencer state encoding, the default line geometry and the
// request priority order used when several cache requests are raised at once.
package l1_pkg;

  // Default line geometry: 256-byte lines, 8-bit byte offset
  localparam int LINE_BYTES_DEF = 256;
  localparam int LINE_WID_DEF   = $clog2(LINE_BYTES_DEF);

  // Sequencer state encoding (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LINE   = 3'd1;
  localparam logic [2:0] ST_SGL_RD = 3'd2;
  localparam logic [2:0] ST_SGL_WR = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd7;

  // Priority order: line refill first, then uncached read, then write-through
  function automatic logic [2:0] pick_request(input logic line_req,
                                              input logic rd_req,
                                              input logic wt_req);
    logic [2:0] next;
    next = ST_IDLE;
    if (line_req) begin
      next = ST_LINE;
    end else if (rd_req) begin
      next = ST_SGL_RD;
    end else if (wt_req) begin
      next = ST_SGL_WR;
    end
    return next;
  endfunction

endpackage

// File: rtl/bus_beat.sv
// bus_beat: one bus beat at a time. A start pulse raises bus_req on the next
// cycle; the first bus_ack while bus_req is high ends the beat, reported as
// beat_done (clean) or beat_fail (bus_err set). With L1_BUS_TIMEOUT_EN defined,
// a watchdog also fails the beat after TIMEOUT cycles without an ack.
module bus_beat
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bus_ack,
  input  logic bus_err,
  output logic bus_req,
  output logic beat_done,
  output logic beat_fail
);

  logic bus_req_q;
  logic bus_req_d;
  logic acked;
  logic timeout_hit;

  // An ack only counts while a request is actually outstanding
  assign acked = bus_req_q & bus_ack;

`ifdef L1_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // Stall counter restarts with every new beat and advances while unanswered
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (start) begin
      wait_cnt_d = '0;
    end else if (bus_req_q && !bus_ack) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The TIMEOUT-th unanswered request cycle aborts the beat
  assign timeout_hit = bus_req_q && !bus_ack &&
                       (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  assign beat_done = acked & ~bus_err;
  assign beat_fail = (acked & bus_err) | timeout_hit;
  assign bus_req   = bus_req_q;

  // Request rises after start and falls once the beat has ended either way
  always_comb begin
    bus_req_d = bus_req_q;
    if (start) begin
      bus_req_d = 1'b1;
    end else if (acked || timeout_hit) begin
      bus_req_d = 1'b0;
    end
  end

  // Request register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_q <= 1'b0;
    end else begin
      bus_req_q <= bus_req_d;
    end
  end

endmodule

// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl: bus-side sequencer for the direct-mapped L1-I cache.
// Serves line refills (LINE_BYTES byte beats), single uncached byte reads and
// single write-through bytes over an 8-bit req/ack bus. Refill bytes come back
// with addr_count/line_write; every transaction ends in trans_rdy or bus_error.
// Optional ack watchdog: define L1_BUS_TIMEOUT_EN (limit set by TIMEOUT).
module l1_refill_ctrl
  import l1_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int LINE_WID   = (LINE_BYTES == LINE_BYTES_DEF) ? LINE_WID_DEF
                                                            : $clog2(LINE_BYTES),
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_line_req,
  input  logic                  read_req,
  input  logic                  write_through_req,
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [7:0]            wt_data,
  output logic [7:0]            line_data,
  output logic [LINE_WID:0]     addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [ADDR_WIDTH-1:0] pa_q;
  logic [ADDR_WIDTH-1:0] pa_d;
  logic [7:0]            wdata_q;
  logic [7:0]            wdata_d;
  logic [LINE_WID:0]     count_q;
  logic [LINE_WID:0]     count_d;
  logic [7:0]            line_data_q;
  logic [7:0]            line_data_d;
  logic                  line_write_q;
  logic                  line_write_d;
  logic                  refill_q;
  logic                  refill_d;

  logic                  beat_start;
  logic                  beat_done;
  logic                  beat_fail;
  logic                  last_offset;

  bus_beat #(
    .TIMEOUT   (TIMEOUT)
  ) u_bus_beat (
    .clk       (clk),
    .rst       (rst),
    .start     (beat_start),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .beat_done (beat_done),
    .beat_fail (beat_fail)
  );

  assign last_offset = (count_q[LINE_WID-1:0] == {LINE_WID{1'b1}});

  // Sequencer: pick a request, run its beats, then one DONE or FAIL cycle
  always_comb begin
    state_d      = state_q;
    pa_d         = pa_q;
    wdata_d      = wdata_q;
    count_d      = count_q;
    line_data_d  = line_data_q;
    line_write_d = 1'b0;
    refill_d     = 1'b0;
    beat_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = pick_request(read_line_req, read_req, write_through_req);
        if (state_d != ST_IDLE) begin
          pa_d       = pa;
          beat_start = 1'b1;
        end
        if (state_d == ST_LINE) begin
          count_d = '0;
        end
        if (state_d == ST_SGL_WR) begin
          wdata_d = wt_data;
        end
      end
      ST_LINE: begin
        if (beat_fail) begin
          state_d = ST_FAIL;
        end else if (beat_done) begin
          line_data_d  = bus_rdata;
          line_write_d = 1'b1;
        end else if (line_write_q) begin
          count_d = count_q + 1'b1;
          if (last_offset) begin
            state_d  = ST_DONE;
            refill_d = 1'b1;
          end else begin
            beat_start = 1'b1;
          end
        end
      end
      ST_SGL_RD: begin
        if (beat_fail) begin
          state_d = ST_FAIL;
        end else if (beat_done) begin
          line_data_d = bus_rdata;
          state_d     = ST_DONE;
        end
      end
      ST_SGL_WR: begin
        if (beat_fail) begin
          state_d = ST_FAIL;
        end else if (beat_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset drops every strobe and forgets a partial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pa_q         <= '0;
      wdata_q      <= '0;
      count_q      <= '0;
      line_data_q  <= '0;
      line_write_q <= 1'b0;
      refill_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pa_q         <= pa_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      line_data_q  <= line_data_d;
      line_write_q <= line_write_d;
      refill_q     <= refill_d;
    end
  end

  assign line_data          = line_data_q;
  assign addr_count         = count_q;
  assign line_write         = line_write_q;
  assign cache_entry_refill = refill_q;
  assign trans_rdy          = (state_q == ST_DONE);
  assign bus_error          = (state_q == ST_FAIL);
  assign bus_we             = (state_q == ST_SGL_WR);
  assign bus_wdata          = wdata_q;
  assign bus_addr           = (state_q == ST_LINE)
                              ? {pa_q[ADDR_WIDTH-1:LINE_WID], count_q[LINE_WID-1:0]}
                              : pa_q;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb_l1_refill_ctrl: directed and randomized bench for l1_refill_ctrl.
// A bus responder serves a pseudo-random byte memory; expectations come from
// that memory and simple beat/cycle arithmetic over the transaction rules.
// The watchdog scenario runs only when L1_BUS_TIMEOUT_EN is defined.
module tb_l1_refill_ctrl;

  localparam int AW    = 24;
  localparam int LB    = 256;

  logic          clk;
  logic          rst;
  logic          read_line_req;
  logic          read_req;
  logic          write_through_req;
  logic [AW-1:0] pa;
  logic [7:0]    wt_data;
  logic [7:0]    line_data;
  logic [8:0]    addr_count;
  logic          line_write;
  logic          cache_entry_refill;
  logic          trans_rdy;
  logic          bus_error;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic [7:0]    bus_rdata;
  logic          bus_ack;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  // Responder configuration and beat log
  int            ackGap   = 2;
  int            errBeat  = -1;
  bit            noAck    = 1'b0;
  bit            spurious = 1'b1;
  int            beatIdx  = 0;
  int            reqCycles = 0;
  logic [AW-1:0] ackAddr[$];
  bit            ackWe[$];
  logic [7:0]    ackWdata[$];
  logic [7:0]    memTable[256];

  // Per-transaction observations
  int            lwCnt[$];
  logic [7:0]    lwData[$];
  int            cycles;
  int            refillPulses;
  bit            endRdy;
  bit            endErr;
  bit            endRefill;
  int            endAddrCount;
  logic [7:0]    endLineData;
  logic [7:0]    lastLineData;
  bit            lineDataKnown = 1'b0;

  l1_refill_ctrl #(
    .ADDR_WIDTH         (AW),
    .LINE_BYTES         (LB),
    .TIMEOUT            (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .read_line_req      (read_line_req),
    .read_req           (read_req),
    .write_through_req  (write_through_req),
    .pa                 (pa),
    .wt_data            (wt_data),
    .line_data          (line_data),
    .addr_count         (addr_count),
    .line_write         (line_write),
    .cache_entry_refill (cache_entry_refill),
    .trans_rdy          (trans_rdy),
    .bus_error          (bus_error),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_rdata          (bus_rdata),
    .bus_ack            (bus_ack),
    .bus_err            (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory seen through the bus
  function automatic logic [7:0] memByte(input logic [AW-1:0] a);
    return memTable[a[7:0]] ^ a[15:8] ^ a[23:16];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Bus responder: acks the ackGap-th request cycle, stray acks while idle
  initial begin
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        if (noAck) begin
          bus_ack   = 1'b0;
          bus_err   = 1'($urandom_range(0, 1));
          bus_rdata = 8'($urandom);
        end else begin
          reqCycles++;
          if (reqCycles >= ackGap) begin
            bus_ack   = 1'b1;
            bus_err   = (beatIdx == errBeat);
            bus_rdata = memByte(bus_addr);
            ackAddr.push_back(bus_addr);
            ackWe.push_back(bus_we);
            ackWdata.push_back(bus_wdata);
            beatIdx++;
            reqCycles = 0;
          end else begin
            bus_ack   = 1'b0;
            bus_err   = 1'($urandom_range(0, 1));
            bus_rdata = 8'($urandom);
          end
        end
      end else begin
        reqCycles = 0;
        bus_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_err   = 1'($urandom_range(0, 1));
        bus_rdata = 8'($urandom);
      end
    end
  end

  // Raise a request for the one sampling edge, then scramble the inputs
  task automatic applyStimulus(input bit line, input bit rd, input bit wt,
                               input logic [AW-1:0] a, input logic [7:0] d,
                               input bit keepWt);
    ackAddr.delete();
    ackWe.delete();
    ackWdata.delete();
    beatIdx           = 0;
    pa                = a;
    wt_data           = d;
    read_line_req     = line;
    read_req          = rd;
    write_through_req = wt;
    @(posedge clk);
    #1;
    read_line_req = 1'b0;
    read_req      = 1'b0;
    if (!keepWt) begin
      write_through_req = 1'b0;
      pa                = 24'($urandom);
      wt_data           = 8'($urandom);
    end
  endtask

  // Observe cycles until trans_rdy or bus_error, bounded by budget
  task automatic collectTxn(input int budget);
    bit done;
    done = 1'b0;
    lwCnt.delete();
    lwData.delete();
    cycles       = 0;
    refillPulses = 0;
    endRdy       = 1'b0;
    endErr       = 1'b0;
    endRefill    = 1'b0;
    endAddrCount = 0;
    endLineData  = 8'h00;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus_we) write_through_req = 1'b0;
      if (line_write) begin
        lwCnt.push_back(int'(addr_count));
        lwData.push_back(line_data);
      end
      if (cache_entry_refill) refillPulses++;
      if (trans_rdy || bus_error) begin
        done         = 1'b1;
        endRdy       = trans_rdy;
        endErr       = bus_error;
        endRefill    = cache_entry_refill;
        endAddrCount = int'(addr_count);
        endLineData  = line_data;
      end
    end
    checkOutput("txn_terminates", 32'(done), 32'd1);
  endtask

  // Refill beats: offsets in order, bytes from memory at the line address
  task automatic checkLineBeats(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] expAddr;
    checkOutput("line_write_pulses", 32'(lwCnt.size()), 32'(n));
    for (int i = 0; i < n && i < lwCnt.size(); i++) begin
      expAddr = (a & 24'hFFFF00) | 24'(i);
      checkOutput("lw_addr_count", 32'(lwCnt[i]), 32'(i));
      checkOutput("lw_data", 32'(lwData[i]), 32'(memByte(expAddr)));
      if (i < ackAddr.size()) begin
        checkOutput("beat_bus_addr", 32'(ackAddr[i]), 32'(expAddr));
        checkOutput("beat_we", 32'(ackWe[i]), 32'd0);
      end
    end
  endtask

  // One complete transaction: kind 0=line, 1=read, 2=write; errAt<0 = clean
  task automatic runAndCheck(input int kind, input logic [AW-1:0] a,
                             input logic [7:0] d, input int gap, input int errAt);
    bit isErr;
    int good;
    int expCycles;
    ackGap  = gap;
    errBeat = errAt;
    isErr   = (errAt >= 0);
    applyStimulus(kind == 0, kind == 1, kind == 2, a, d, 1'b0);
    collectTxn(1200);
    if (kind == 0) begin
      good      = isErr ? errAt : LB;
      expCycles = isErr ? errAt * (gap + 1) + gap + 1 : LB * (gap + 1) + 1;
      checkLineBeats(a, good);
      checkOutput("line_ack_beats", 32'(ackAddr.size()), 32'(good + (isErr ? 1 : 0)));
      checkOutput("line_refill_pulses", 32'(refillPulses), isErr ? 32'd0 : 32'd1);
      if (!isErr) begin
        checkOutput("line_end_addr_count", 32'(endAddrCount), 32'(LB));
        checkOutput("line_end_refill", 32'(endRefill), 32'd1);
      end
      if (good > 0) begin
        lastLineData  = memByte((a & 24'hFFFF00) | 24'(good - 1));
        lineDataKnown = 1'b1;
      end
    end else begin
      expCycles = gap + 1;
      checkOutput("single_lw_pulses", 32'(lwCnt.size()), 32'd0);
      checkOutput("single_refill_pulses", 32'(refillPulses), 32'd0);
      checkOutput("single_ack_beats", 32'(ackAddr.size()), 32'd1);
      if (ackAddr.size() > 0) begin
        checkOutput("single_bus_addr", 32'(ackAddr[0]), 32'(a));
        checkOutput("single_bus_we", 32'(ackWe[0]), 32'(kind == 2));
        if (kind == 2) checkOutput("single_bus_wdata", 32'(ackWdata[0]), 32'(d));
      end
      if (kind == 1) begin
        if (!isErr) begin
          lastLineData  = memByte(a);
          lineDataKnown = 1'b1;
        end else begin
          lineDataKnown = 1'b0;
        end
      end
      if (lineDataKnown) checkOutput("single_line_data", 32'(endLineData), 32'(lastLineData));
    end
    checkOutput("txn_cycles", 32'(cycles), 32'(expCycles));
    checkOutput("txn_trans_rdy", 32'(endRdy), 32'(!isErr));
    checkOutput("txn_bus_error", 32'(endErr), 32'(isErr));
    @(negedge clk);
    checkOutput("idle_bus_req", 32'(bus_req), 32'd0);
    checkOutput("idle_strobes", 32'({trans_rdy, bus_error, cache_entry_refill, line_write}), 32'd0);
  endtask

  // Directed scenarios followed by randomized transactions
  initial begin
    int n;
    bit seen;
    int weCount;
    int kind;
    int gap;
    int errAt;
    logic [AW-1:0] a;
    logic [7:0] d;

    for (int i = 0; i < 256; i++) memTable[i] = 8'($urandom);
    rst               = 1'b1;
    read_line_req     = 1'b0;
    read_req          = 1'b0;
    write_through_req = 1'b0;
    pa                = '0;
    wt_data           = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
    checkOutput("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    checkOutput("rst_line_data", 32'(line_data), 32'd0);
    checkOutput("rst_addr_count", 32'(addr_count), 32'd0);
    checkOutput("rst_line_write", 32'(line_write), 32'd0);
    checkOutput("rst_refill", 32'(cache_entry_refill), 32'd0);
    checkOutput("rst_trans_rdy", 32'(trans_rdy), 32'd0);
    checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] refill at 0x012345, ack every 2nd cycle");
    runAndCheck(0, 24'h012345, 8'h00, 2, -1);

    $display("[TB] single read at 0x800010");
    memTable[8'h10] = 8'hA5 ^ 8'h00 ^ 8'h80;
    runAndCheck(1, 24'h800010, 8'h00, 1, -1);
    checkOutput("read_a5_line_data", 32'(endLineData), 32'h0A5);

    $display("[TB] write-through at 0x800020");
    runAndCheck(2, 24'h800020, 8'h3C, 3, -1);

    $display("[TB] refill with bus error on beat 17");
    runAndCheck(0, 24'($urandom), 8'h00, 1, 17);

    $display("[TB] refill and write-through raised together");
    ackGap  = 1;
    errBeat = -1;
    a       = 24'h4455AA;
    d       = 8'h5A;
    applyStimulus(1'b1, 1'b0, 1'b1, a, d, 1'b1);
    collectTxn(1200);
    checkLineBeats(a, LB);
    checkOutput("prio_refill_first", 32'(endRefill), 32'd1);
    checkOutput("prio_refill_rdy", 32'(endRdy), 32'd1);
    weCount = 0;
    foreach (ackWe[i]) if (ackWe[i]) weCount++;
    checkOutput("prio_no_write_during_refill", 32'(weCount), 32'd0);
    ackAddr.delete();
    ackWe.delete();
    ackWdata.delete();
    collectTxn(50);
    checkOutput("prio_write_beats", 32'(ackAddr.size()), 32'd1);
    if (ackAddr.size() > 0) begin
      checkOutput("prio_write_we", 32'(ackWe[0]), 32'd1);
      checkOutput("prio_write_addr", 32'(ackAddr[0]), 32'(a));
      checkOutput("prio_write_data", 32'(ackWdata[0]), 32'(d));
    end
    checkOutput("prio_write_rdy", 32'(endRdy), 32'd1);
    lastLineData  = memByte(a | 24'h0000FF);
    lineDataKnown = 1'b1;
    @(negedge clk);
    checkOutput("prio_idle_bus_req", 32'(bus_req), 32'd0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 8; t++) begin
      kind  = int'($urandom_range(0, 2));
      gap   = int'($urandom_range(1, 3));
      errAt = -1;
      if ($urandom_range(0, 3) == 0) errAt = (kind == 0) ? int'($urandom_range(0, 255)) : 0;
      runAndCheck(kind, 24'($urandom), 8'($urandom), gap, errAt);
    end

`ifdef L1_BUS_TIMEOUT_EN
    $display("[TB] ack watchdog with a silent bus");
    noAck = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h123456, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("to_req_rise", 32'(bus_req), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus_error) seen = 1'b1;
    end
    checkOutput("to_error_seen", 32'(seen), 32'd1);
    checkOutput("to_cycles", 32'(n), 32'd8);
    checkOutput("to_req_dropped", 32'(bus_req), 32'd0);
    @(negedge clk);
    checkOutput("to_error_one_cycle", 32'(bus_error), 32'd0);
    noAck = 1'b0;
`endif

    $display("[TB] async reset in the middle of a refill");
    ackGap  = 1;
    errBeat = -1;
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h0ABCDE, 8'h00, 1'b0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (line_write && n > 6) seen = 1'b1;
    end
    checkOutput("arst_mid_refill_reached", 32'(seen), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("arst_line_write", 32'(line_write), 32'd0);
    checkOutput("arst_addr_count", 32'(addr_count), 32'd0);
    checkOutput("arst_strobes", 32'({cache_entry_refill, trans_rdy, bus_error}), 32'd0);
    checkOutput("arst_line_data", 32'(line_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    refillPulses = 0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (cache_entry_refill) refillPulses++;
      if (bus_req) n++;
    end
    checkOutput("arst_no_tag_update", 32'(refillPulses), 32'd0);
    checkOutput("arst_bus_quiet", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_refill_ctrl.md
Name: l1_refill_ctrl

Overview:
- Bus-side sequencer for the direct-mapped L1-I cache. Serves the cache's three request levels: line refill, single uncached read and single write-through.
- Drives the 8-bit external bus with a req/ack handshake.
- Returns refill bytes with addr_count and line_write strobes, then terminates each transaction with trans_rdy or bus_error.
- Sits between the L1 cache and the SoC bus.

Parameters:
- ADDR_WIDTH, 24, physical byte address width.
- LINE_BYTES, 256, bytes per cache line (128 halfwords); must be a power of 2.
- LINE_WID, log2(LINE_BYTES) = 8, byte-offset width within a line.
- TIMEOUT, 255, ack watchdog limit in cycles. Used only with L1_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- read_line_req  in  1  level; refill the line containing pa.
- read_req  in  1  level; single uncached byte read at pa.
- write_through_req  in  1  level; single byte write of wt_data at pa.
- pa  in  ADDR_WIDTH  request byte address.
- wt_data  in  8  write-through data.
- line_data  out  8  returned byte (refill or single read).
- addr_count  out  LINE_WID+1  byte offset of the current refill byte.
- line_write  out  1  one-cycle strobe; line_data/addr_count valid for the cache RAM write.
- cache_entry_refill  out  1  one-cycle strobe; tag update after a complete line.
- trans_rdy  out  1  one-cycle transaction-complete pulse.
- bus_error  out  1  one-cycle transaction-aborted pulse.
- bus_req  out  1  bus request; held until bus_ack.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_WIDTH  bus byte address.
- bus_wdata  out  8  bus write data.
- bus_rdata  in  8  bus read data; valid with bus_ack.
- bus_ack  in  1  beat complete.
- bus_err  in  1  beat failed; qualified by bus_ack.

Behaviour:
- Reset: all outputs are 0. State is IDLE and addr_count is 0.
- States: IDLE, LINE, SGL_RD, SGL_WR, DONE, FAIL.
- IDLE:
  - Request priority is read_line_req > read_req > write_through_req.
  - Latch pa on entry.
  - LINE: addr_count is cleared.
  - SGL_WR: wt_data is latched into bus_wdata.
  - bus_req rises in the cycle after the request is sampled (registered).
- LINE:
  - bus_addr = {pa[ADDR_WIDTH-1:LINE_WID], addr_count[LINE_WID-1:0]}.
  - Each bus_ack with bus_err=0 gives, in the next cycle:
    - line_data = bus_rdata;
    - line_write = 1 with addr_count still equal to the acked offset;
    - addr_count then increments.
  - bus_req drops for exactly one cycle between beats.
  - After the ack at offset LINE_BYTES-1: the final line_write fires, addr_count reaches LINE_BYTES (MSB set), and the state goes to DONE.
  - In DONE, cache_entry_refill = 1 and trans_rdy = 1 together.
- SGL_RD: on ack, line_data = bus_rdata, then DONE (trans_rdy only).
- SGL_WR: bus_we = 1, then DONE on ack.
- DONE: one cycle, then IDLE. Requests are not sampled in DONE.
- Any ack with bus_err=1:
  - go to FAIL;
  - no line_write for that beat;
  - cache_entry_refill is never raised for the aborted line.
- FAIL: bus_error = 1 for one cycle, then IDLE.
- Request deassertion mid-transaction is ignored; the transaction completes normally.
- Async reset mid-refill: bus_req drops immediately, all strobes clear, and the partial line is not tagged.
- bus_ack while bus_req=0 is ignored.
- line_data holds its last value between transactions.

Optional Feature:
- Macro: L1_BUS_TIMEOUT_EN.
- Defined:
  - a counter clears on each bus_req rise and counts while bus_req=1 and bus_ack=0;
  - reaching TIMEOUT aborts the transaction exactly as bus_err does (FAIL, then bus_error pulse).
- Undefined: no counter; the controller waits for bus_ack indefinitely.

Decomposition:
- Shared package l1_pkg:
  - state encoding constants (IDLE=0, LINE=1, SGL_RD=2, SGL_WR=3, DONE=4, FAIL=7);
  - LINE_BYTES and LINE_WID defaults;
  - priority order.
- Sub-module bus_beat (request/ack handshake plus optional watchdog), instantiated once. It outputs beat_done and beat_fail to the sequencer FSM.

Test Plan:
- Refill at pa=0x012345, bus acking every 2nd cycle:
  - 256 line_write pulses at addresses 0x012300..0x0123FF, addr_count 0..255 in order, data matching;
  - then one cycle with cache_entry_refill = trans_rdy = 1 and addr_count = 256.
- read_req at pa=0x800010, bus_rdata=0xA5: line_data=0xA5 and one trans_rdy pulse; no line_write and no cache_entry_refill.
- write_through_req at pa=0x800020, wt_data=0x3C: one bus beat with bus_we=1, addr 0x800020, data 0x3C; then trans_rdy.
- bus_err on beat 17 of a refill: 17 line_write pulses, then bus_error for one cycle; no cache_entry_refill; IDLE the following cycle.
- read_line_req and write_through_req asserted together: line refill served first; the write is served only after DONE.
- Timeout (macro on, TIMEOUT=8, bus never acks):
  - bus_error exactly 8 cycles after bus_req rises;
  - async rst asserted mid-refill clears all outputs in the same cycle.
